sa_2d_stream_top: RTL and testbench

Parametrised, handshaked top for the output-stationary 2D systolic MAC array. It accepts a stream of K operand beats, where each beat is one A vector (one lane per row) and one B vector (one lane per column), with in_valid/in_ready flow control. It skews the operands diagonally into a VPE×HPE grid of accumulating PEs and drains the pipeline. It then presents the registered result matrix with out_valid/out_ready, replacing the fixed-width, free-running register wrapper around the array core.

---
 rtl/sa_pkg.sv | 14 +
 rtl/sa_pe.sv | 49 ++++
 rtl/sa_2d_stream_top.sv | 157 +++++++++++++++
 tb/tb_sa_2d_stream_top.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the 2D systolic MAC array.
package sa_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} sa_state_t;

    function automatic int acc_width(input int width, input int kmax);
        return 2 * width + $clog2(kmax);
    endfunction

    function automatic int drain_cycles(input int hpe, input int vpe);
        return hpe + vpe - 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One MAC processing element: forwards A right and B down, accumulates a*b.
// SA_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module sa_pe #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [ACC_W-1:0] acc
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   prod_ext;

    // The low 2*WIDTH bits of the product of extended operands equal the true product
    always_comb begin
`ifdef SA_SIGNED_EN
        a_ext    = {{WIDTH{a_in[WIDTH-1]}}, a_in};
        b_ext    = {{WIDTH{b_in[WIDTH-1]}}, b_in};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
`else
        a_ext    = {{WIDTH{1'b0}}, a_in};
        b_ext    = {{WIDTH{1'b0}}, b_in};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*WIDTH){1'b0}}, prod};
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/sa_2d_stream_top.sv
// Handshaked stream top for the output-stationary VPE x HPE systolic MAC array.
// SA_SIGNED_EN (in sa_pe) selects signed operand arithmetic.
module sa_2d_stream_top
    import sa_pkg::*;
#(
    parameter int HPE   = 4,
    parameter int VPE   = 4,
    parameter int WIDTH = 8,
    parameter int KMAX  = 16,
    localparam int ACC_W = acc_width(WIDTH, KMAX)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH*VPE-1:0]       A1,
    input  logic [WIDTH*HPE-1:0]       B1,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [ACC_W*HPE*VPE-1:0]   YY1,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int DRAIN_N = drain_cycles(HPE, VPE);
    localparam int BCW     = $clog2(KMAX);
    localparam int DCW     = $clog2(DRAIN_N + 1);

    sa_state_t      state_q, state_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           accept, clr, load_y;

    logic [WIDTH-1:0] a_row [VPE];
    logic [WIDTH-1:0] b_col [HPE];
    logic [WIDTH-1:0] a_o   [VPE][HPE];
    logic [WIDTH-1:0] b_o   [VPE][HPE];
    logic [ACC_W-1:0] acc_o [VPE][HPE];

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign clr       = (state_q == DONE) && out_ready;
    assign load_y    = (state_q == DRAIN) && (drain_q == DCW'(DRAIN_N));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

    // DRAIN holds one cycle beyond the skew depth so YY1 captures the final accumulation
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                drain_d = '0;
                if (in_last) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    beat_d  = BCW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: if (in_valid) begin
                if (in_last || beat_q == BCW'(KMAX - 1)) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: if (drain_q == DCW'(DRAIN_N)) begin
                drain_d = '0;
                state_d = DONE;
            end else begin
                drain_d = drain_q + 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar r = 0; r < VPE; r++) begin : g_askew
        logic [WIDTH-1:0] sk [r+1];
        always_ff @(posedge CLK) begin
            if (!RST) begin
                for (int unsigned i = 0; i <= r; i++) sk[i] <= '0;
            end else begin
                sk[0] <= accept ? A1[r*WIDTH +: WIDTH] : '0;
                for (int unsigned i = 1; i <= r; i++) sk[i] <= sk[i-1];
            end
        end
        assign a_row[r] = sk[r];
    end

    for (genvar c = 0; c < HPE; c++) begin : g_bskew
        logic [WIDTH-1:0] sk [c+1];
        always_ff @(posedge CLK) begin
            if (!RST) begin
                for (int unsigned i = 0; i <= c; i++) sk[i] <= '0;
            end else begin
                sk[0] <= accept ? B1[c*WIDTH +: WIDTH] : '0;
                for (int unsigned i = 1; i <= c; i++) sk[i] <= sk[i-1];
            end
        end
        assign b_col[c] = sk[c];
    end

    for (genvar r = 0; r < VPE; r++) begin : g_row
        for (genvar c = 0; c < HPE; c++) begin : g_col
            logic [WIDTH-1:0] a_in, b_in;
            if (c == 0) begin : g_a_edge
                assign a_in = a_row[r];
            end else begin : g_a_fwd
                assign a_in = a_o[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in = b_col[c];
            end else begin : g_b_fwd
                assign b_in = b_o[r-1][c];
            end
            sa_pe #(
                .WIDTH (WIDTH),
                .ACC_W (ACC_W)
            ) u_pe (
                .CLK   (CLK),
                .RST   (RST),
                .clr   (clr),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_o[r][c]),
                .b_out (b_o[r][c]),
                .acc   (acc_o[r][c])
            );
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            YY1 <= '0;
        end else if (load_y) begin
            for (int unsigned r = 0; r < VPE; r++)
                for (int unsigned c = 0; c < HPE; c++)
                    YY1[(r*HPE+c)*ACC_W +: ACC_W] <= acc_o[r][c];
        end
    end

endmodule

// File: tb/tb_sa_2d_stream_top.sv
// Directed, table-driven bench for sa_2d_stream_top at HPE=VPE=2, WIDTH=8, KMAX=4.
module tb_sa_2d_stream_top;

    localparam int HPE   = 2;
    localparam int VPE   = 2;
    localparam int WIDTH = 8;
    localparam int KMAX  = 4;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int YW    = ACC_W * HPE * VPE;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [15:0]   A1 = '0;
    logic [15:0]   B1 = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [YW-1:0] YY1;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_applied = 0;
    int n_miscmp  = 0;

    typedef struct packed {
        logic [2:0]        nb;
        logic [3:0]        lastm;
        logic              gap;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  b;
        logic [3:0][17:0]  y;
    } vec_t;

    vec_t tv [5];

    sa_2d_stream_top #(
        .HPE   (HPE),
        .VPE   (VPE),
        .WIDTH (WIDTH),
        .KMAX  (KMAX)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A1        (A1),
        .B1        (B1),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .YY1       (YY1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int idx, input bit ack);
        vec_t v;
        int   n;
        v = tv[idx];
        for (int k = 0; k < int'(v.nb); k++) begin
            if (v.gap && k > 0) begin
                in_valid = 1'b0;
                repeat (3) tick();
            end
            in_valid = 1'b1;
            A1       = v.a[k];
            B1       = v.b[k];
            in_last  = v.lastm[k];
            chk($sformatf("v%0d_in_ready_b%0d", idx, k), YW'(in_ready), YW'(1));
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_latency", idx), YW'(n), YW'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d_y%0d", idx, i), YW'(YY1[i*ACC_W +: ACC_W]), YW'(v.y[i]));
        chk($sformatf("v%0d_done_in_ready", idx), YW'(in_ready), YW'(0));
        if (ack) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_ack_out_valid", idx), YW'(out_valid), YW'(0));
            chk($sformatf("v%0d_ack_in_ready", idx), YW'(in_ready), YW'(1));
        end
    endtask

    initial begin
        // y[i] is PE(r,c) with i = r*2+c; a/b lane 0 in the low byte
        tv[0] = '{nb: 3'd2, lastm: 4'b0010, gap: 1'b0,
                  a: {16'h0, 16'h0, 16'h0403, 16'h0201},
                  b: {16'h0, 16'h0, 16'h0807, 16'h0605},
                  y: {18'd44, 18'd38, 18'd30, 18'd26}};
        tv[1] = tv[0];
        tv[1].gap = 1'b1;
`ifdef SA_SIGNED_EN
        tv[2] = '{nb: 3'd1, lastm: 4'b0001, gap: 1'b0,
                  a: {16'h0, 16'h0, 16'h0, 16'h00FF},
                  b: {16'h0, 16'h0, 16'h0, 16'h0002},
                  y: {18'd0, 18'd0, 18'd0, 18'h3FFFE}};
        tv[3] = '{nb: 3'd4, lastm: 4'b0000, gap: 1'b0,
                  a: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                  b: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                  y: {18'd4, 18'd4, 18'd4, 18'd4}};
`else
        tv[2] = '{nb: 3'd1, lastm: 4'b0001, gap: 1'b0,
                  a: {16'h0, 16'h0, 16'h0, 16'h00FF},
                  b: {16'h0, 16'h0, 16'h0, 16'h0002},
                  y: {18'd0, 18'd0, 18'd0, 18'd510}};
        tv[3] = '{nb: 3'd4, lastm: 4'b0000, gap: 1'b0,
                  a: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                  b: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                  y: {18'd260100, 18'd260100, 18'd260100, 18'd260100}};
`endif
        tv[4] = '{nb: 3'd3, lastm: 4'b0100, gap: 1'b0,
                  a: {16'h0, 16'h0307, 16'h0100, 16'h140A},
                  b: {16'h0, 16'h0401, 16'h3264, 16'h0302},
                  y: {18'd122, 18'd143, 18'd58, 18'd27}};

        RST = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        chk("reset_yy1", YY1, '0);
        chk("reset_out_valid", YW'(out_valid), YW'(0));
        chk("reset_in_ready", YW'(in_ready), YW'(1));
        tick();

        for (int i = 0; i < 5; i++) run_job(i, 1'b1);

        // Result held in DONE while the producer keeps offering beats
        run_job(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            A1       = 16'hFFFF;
            B1       = 16'hFFFF;
            tick();
            chk("hold_yy1", YY1, YW'(tv[0].y));
            chk("hold_in_ready", YW'(in_ready), YW'(0));
            chk("hold_out_valid", YW'(out_valid), YW'(1));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_in_ready", YW'(in_ready), YW'(1));
        chk("release_out_valid", YW'(out_valid), YW'(0));
        run_job(4, 1'b1);

        // Reset while LOAD holds one accepted beat
        run_job(0, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b0;
        A1       = tv[0].a[0];
        B1       = tv[0].b[0];
        tick();
        chk("midload_state", YW'(in_ready), YW'(1));
        in_valid = 1'b0;
        RST      = 1'b0;
        tick();
        RST      = 1'b1;
        chk("midload_rst_yy1", YY1, '0);
        chk("midload_rst_out_valid", YW'(out_valid), YW'(0));
        chk("midload_rst_in_ready", YW'(in_ready), YW'(1));
        run_job(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
